// File: rtl/tx_fifo.sv
// Transmit block FIFO: 128-bit blocks in, 32-bit words out, MSW first.
// Define TX_FIFO_COUNT_EN to expose the block count as block_count.
module tx_fifo #(
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] tx_fifo_in,
  input  logic         tx_enq,
  input  logic         tx_deq_word,
  input  logic         fix_error,
  output logic [31:0]  HRDATA,
  output logic         full,
  output logic         empty,
  output logic         framing_error
`ifdef TX_FIFO_COUNT_EN
  ,
  output logic [1:0]   block_count
`endif
);

  localparam logic [2:0] CNT_MAX  = 3'(DEPTH);
  localparam logic [1:0] PTR_LAST = 2'(DEPTH - 1);

  logic [127:0] mem [DEPTH];
  logic [1:0]   rptr;
  logic [1:0]   wptr;
  logic [1:0]   widx;
  logic [2:0]   cnt;

  logic         has;
  logic         fix;
  logic         deq;
  logic         pop;
  logic         enq;
  logic [127:0] head;

  function automatic logic [1:0] nxt(
    input logic [1:0] p
  );
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // fix_error wins over a word dequeue in the same cycle
  always_comb begin
    has = (cnt != 3'd0);
    fix = fix_error && (widx != 2'd0);
    deq = tx_deq_word && has && !fix;
    pop = fix || (deq && (widx == 2'd3));
    enq = tx_enq && ((cnt < CNT_MAX) || pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= 2'd0;
      wptr <= 2'd0;
      widx <= 2'd0;
      cnt  <= 3'd0;
    end else begin
      if (enq)
        wptr <= nxt(wptr);
      if (pop)
        rptr <= nxt(rptr);
      if (pop)
        widx <= 2'd0;
      else if (deq)
        widx <= widx + 2'd1;
      unique case ({enq, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq)
      mem[wptr] <= tx_fifo_in;
  end

  always_comb begin
    head   = mem[rptr];
    HRDATA = 32'd0;
    if (has) begin
      unique case (widx)
        2'd0: HRDATA = head[127:96];
        2'd1: HRDATA = head[95:64];
        2'd2: HRDATA = head[63:32];
        2'd3: HRDATA = head[31:0];
      endcase
    end
  end

  assign full          = (cnt == CNT_MAX);
  assign empty         = !has;
  assign framing_error = (widx != 2'd0);

`ifdef TX_FIFO_COUNT_EN
  assign block_count = cnt[1:0];
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: directed table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_tx_fifo;

  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] tx_fifo_in = '0;
  logic         tx_enq = 1'b0;
  logic         tx_deq_word = 1'b0;
  logic         fix_error = 1'b0;
  logic [31:0]  HRDATA;
  logic         full;
  logic         empty;
  logic         framing_error;
`ifdef TX_FIFO_COUNT_EN
  logic [1:0]   block_count;
`endif

  int errs = 0;
  int checks = 0;

  tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .tx_fifo_in(tx_fifo_in),
    .tx_enq(tx_enq),
    .tx_deq_word(tx_deq_word),
    .fix_error(fix_error),
    .HRDATA(HRDATA),
    .full(full),
    .empty(empty),
    .framing_error(framing_error)
`ifdef TX_FIFO_COUNT_EN
    ,
    .block_count(block_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         enq;
    logic         deq;
    logic         fix;
    logic [127:0] din;
    logic         e_empty;
    logic         e_full;
    logic         e_fe;
    logic [31:0]  e_hr;
  } vec_t;

  vec_t tbl[20];

  // reference model: queue of whole blocks plus words already read
  logic [127:0] mq[$];
  int           mw;

  function automatic logic [31:0] word_of(
    input logic [127:0] b,
    input int w
  );
    logic [127:0] t;
    t = b >> (32 * (3 - w));
    return t[31:0];
  endfunction

  task automatic model_step(
    input logic enq,
    input logic deq,
    input logic fix,
    input logic [127:0] din
  );
    logic popped;
    popped = 1'b0;
    if (fix && mw != 0) begin
      void'(mq.pop_front());
      mw = 0;
      popped = 1'b1;
    end else if (deq && mq.size() != 0) begin
      if (mw == 3) begin
        void'(mq.pop_front());
        mw = 0;
        popped = 1'b1;
      end else begin
        mw++;
      end
    end
    if (enq && (mq.size() < DEPTH || popped))
      mq.push_back(din);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(
    input logic enq,
    input logic deq,
    input logic fix,
    input logic [127:0] din
  );
    @(negedge clk);
    tx_enq      = enq;
    tx_deq_word = deq;
    fix_error   = fix;
    tx_fifo_in  = din;
    @(posedge clk);
    model_step(enq, deq, fix, din);
    #1;
    tx_enq      = 1'b0;
    tx_deq_word = 1'b0;
    fix_error   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    mw = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] hr;
    hr = (mq.size() != 0) ? word_of(mq[0], mw) : 32'd0;
    chk({tag, " hr"}, HRDATA, hr);
    chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, " full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, " fe"}, 32'(framing_error), 32'(mw != 0));
`ifdef TX_FIFO_COUNT_EN
    chk({tag, " cnt"}, 32'(block_count), 32'(mq.size()));
`endif
  endtask

  function automatic vec_t mk(
    input logic enq, input logic deq, input logic fix,
    input logic [127:0] din, input logic e_empty,
    input logic e_full, input logic e_fe, input logic [31:0] e_hr
  );
    vec_t v;
    v.enq = enq; v.deq = deq; v.fix = fix; v.din = din;
    v.e_empty = e_empty; v.e_full = e_full;
    v.e_fe = e_fe; v.e_hr = e_hr;
    return v;
  endfunction

  initial begin
    logic [127:0] b1, b2, b3, bx, bd, ba;
    b1 = {32'h11, 32'h22, 32'h33, 32'h44};
    b2 = {32'h55, 32'h66, 32'h77, 32'h88};
    b3 = {32'h99, 32'hAA, 32'hBB, 32'hCC};
    bx = {4{32'hDEAD_BEEF}};
    bd = {32'hD1, 32'hD2, 32'hD3, 32'hD4};
    ba = {32'hAA, 32'hBB, 32'hCC, 32'hDD};

    tbl[0]  = mk(1, 0, 0, b1, 0, 0, 0, 32'h11);
    tbl[1]  = mk(1, 0, 0, b2, 0, 0, 0, 32'h11);
    tbl[2]  = mk(1, 0, 0, b3, 0, 1, 0, 32'h11);
    tbl[3]  = mk(1, 0, 0, bx, 0, 1, 0, 32'h11);
    tbl[4]  = mk(0, 1, 0, 0,  0, 1, 1, 32'h22);
    tbl[5]  = mk(0, 1, 0, 0,  0, 1, 1, 32'h33);
    tbl[6]  = mk(0, 1, 0, 0,  0, 1, 1, 32'h44);
    tbl[7]  = mk(1, 1, 0, bd, 0, 1, 0, 32'h55);
    tbl[8]  = mk(0, 1, 0, 0,  0, 1, 1, 32'h66);
    tbl[9]  = mk(0, 1, 0, 0,  0, 1, 1, 32'h77);
    tbl[10] = mk(0, 1, 0, 0,  0, 1, 1, 32'h88);
    tbl[11] = mk(0, 1, 0, 0,  0, 0, 0, 32'h99);
    tbl[12] = mk(0, 1, 0, 0,  0, 0, 1, 32'hAA);
    tbl[13] = mk(0, 1, 1, 0,  0, 0, 0, 32'hD1);
    tbl[14] = mk(0, 0, 1, 0,  0, 0, 0, 32'hD1);
    tbl[15] = mk(0, 1, 0, 0,  0, 0, 1, 32'hD2);
    tbl[16] = mk(0, 1, 0, 0,  0, 0, 1, 32'hD3);
    tbl[17] = mk(0, 1, 0, 0,  0, 0, 1, 32'hD4);
    tbl[18] = mk(0, 1, 0, 0,  1, 0, 0, 32'h0);
    tbl[19] = mk(0, 1, 0, 0,  1, 0, 0, 32'h0);

    mw = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst fe", 32'(framing_error), 32'd0);
    chk("rst hr", HRDATA, 32'd0);

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].enq, tbl[i].deq, tbl[i].fix, tbl[i].din);
      chk($sformatf("tbl%0d hr", i), HRDATA, tbl[i].e_hr);
      chk($sformatf("tbl%0d empty", i),
          32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d full", i),
          32'(full), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d fe", i),
          32'(framing_error), 32'(tbl[i].e_fe));
    end

    do_reset();
    cyc(1, 0, 0, ba);
    chk("single first hr", HRDATA, 32'hAA);
    chk("single first empty", 32'(empty), 32'd0);
    cyc(0, 1, 0, 0);
    chk("single deq1 hr", HRDATA, 32'hBB);
    chk("single deq1 fe", 32'(framing_error), 32'd1);
    repeat (3) cyc(0, 1, 0, 0);
    chk("single drained empty", 32'(empty), 32'd1);
    chk("single drained fe", 32'(framing_error), 32'd0);

    cyc(1, 0, 0, {32'hA1, 32'hA2, 32'hA3, 32'hA4});
    cyc(1, 0, 0, {32'hB1, 32'hB2, 32'hB3, 32'hB4});
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("fix fe", 32'(framing_error), 32'd0);
    chk("fix hr", HRDATA, 32'hB1);
`ifdef TX_FIFO_COUNT_EN
    chk("fix cnt", 32'(block_count), 32'd1);
`endif
    cyc(0, 0, 1, 0);
    chk_model("fix idle");

    do_reset();
    cyc(1, 0, 0, b1);
    cyc(1, 0, 0, b2);
    cyc(0, 1, 0, 0);
    chk("pre-rst fe", 32'(framing_error), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    mq.delete();
    mw = 0;
    #1;
    chk("async rst empty", 32'(empty), 32'd1);
    chk("async rst fe", 32'(framing_error), 32'd0);
    chk("async rst hr", HRDATA, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic e, d, f;
      e = ($urandom_range(99) < 45);
      d = ($urandom_range(99) < 60);
      f = ($urandom_range(99) < 8);
      cyc(e, d, f, {$urandom, $urandom, $urandom, $urandom});
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
